// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage placed directly in front of the instruction memory wrapper.
// It owns the program counter, issues single-word read requests, and collects
// each registered response (with its PC tag) into a small FIFO for decode.
// Branch/jump redirects flush the FIFO and drop any response that lands in
// the redirect cycle, so decode never sees a stale instruction.
//
// Optional feature macro: FETCH_PERF_EN
//   When defined, adds perf_fetched (pops) and perf_dropped (responses thrown
//   away by redirect/flush) counters. Functional behaviour is unchanged.
//
// Handshakes:
//   instr_valid/instr_ready : the head entry transfers on a cycle where both
//     are high (and no redirect is present). While instr_valid is high and
//     instr_ready is low, instr/instr_pc hold their value.
//   mem_request/mem_valid   : every request is answered by exactly one
//     mem_valid pulse on the following cycle; the memory has no ready.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,

    // Memory wrapper request side
    output logic        mem_request,
    output logic        mem_we_re,
    output logic [3:0]  mem_mask,
    output logic [7:0]  mem_address,
    output logic [31:0] mem_data_in,

    // Memory wrapper response side
    input  logic        mem_valid,
    input  logic [31:0] mem_data_out,

    // Decode side
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,

    // Redirect from execute
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,

`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
`endif

    // Fetch FSM state for observation
    output logic [1:0]  o_dbg_state
);

    // FIFO pointer width and a counter width that can hold BUF_DEPTH + 1
    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 2;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_next_state;

    logic [31:0]     r_fetch_pc;      // PC of the next sequential fetch
    logic [31:0]     r_resp_pc;       // PC tag for the response in flight
    logic            r_inflight;      // one request awaiting its response

    logic [CW-1:0]   r_occ;           // number of valid FIFO entries
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [31:0]     r_buf_instr [BUF_DEPTH];
    logic [31:0]     r_buf_pc    [BUF_DEPTH];

    logic [31:0]     w_redirect_pc;   // redirect target with the byte offset cleared
    logic            w_pop;
    logic            w_resp_ok;       // response that belongs to a live request
    logic            w_push;
    logic [CW-1:0]   w_credit_cnt;
    logic            w_credit;
    logic            w_issue;
    logic [31:0]     w_issue_pc;
    logic            w_unused;

    // -------------------------------------------------------------------------
    // Shared combinational terms
    // -------------------------------------------------------------------------
    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
    assign w_unused      = ^redirect_pc[1:0];

    // A redirect cycle never pops: the head is about to be flushed anyway.
    assign w_pop     = instr_valid && instr_ready && !redirect_valid;

    // Responses are only meaningful while a request is outstanding; a
    // response racing a redirect is dropped rather than pushed.
    assign w_resp_ok = mem_valid && r_inflight;
    assign w_push    = w_resp_ok && !redirect_valid;

    // Issuing is safe when the FIFO can hold everything already stored or
    // on its way back, after accounting for this cycle's pop.
    assign w_credit_cnt = r_occ + CW'(r_inflight) - CW'(w_pop);
    assign w_credit     = (w_credit_cnt < CW'(BUF_DEPTH));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_BOOT:  w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = (redirect_valid || w_credit) ? ST_FETCH : ST_HOLD;
            ST_HOLD:  w_next_state = (redirect_valid || w_credit) ? ST_FETCH : ST_HOLD;
            default:  w_next_state = ST_BOOT;
        endcase
    end

    // FSM: request decode (a redirect outside BOOT always issues its target)
    always_comb begin
        w_issue    = 1'b0;
        w_issue_pc = r_fetch_pc;
        unique case (r_state)
            ST_FETCH, ST_HOLD: begin
                if (redirect_valid) begin
                    w_issue    = 1'b1;
                    w_issue_pc = w_redirect_pc;
                end else if ((r_state == ST_FETCH) && w_credit) begin
                    w_issue    = 1'b1;
                end
            end
            default: begin
                w_issue    = 1'b0;
                w_issue_pc = r_fetch_pc;
            end
        endcase
    end

    // Memory interface: address is forced to zero when no request is issued
    assign mem_request = w_issue;
    assign mem_address = w_issue ? w_issue_pc[9:2] : 8'h00;
    assign mem_we_re   = 1'b0;
    assign mem_mask    = 4'b1111;
    assign mem_data_in = 32'h0000_0000;
    assign o_dbg_state = r_state;

    // -------------------------------------------------------------------------
    // Program counter, response tag and outstanding-request flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= 32'h0000_0000;
            r_inflight <= 1'b0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= w_issue_pc + 32'd4;
                r_resp_pc  <= w_issue_pc;
            end else if ((r_state == ST_BOOT) && redirect_valid) begin
                // Redirect during BOOT: the target becomes the first fetch
                r_fetch_pc <= w_redirect_pc;
            end

            if (w_issue) begin
                r_inflight <= 1'b1;
            end else if (mem_valid) begin
                r_inflight <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO control: pointers and occupancy, cleared by a redirect flush
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (redirect_valid) begin
            r_occ    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage: payload only, qualified by occupancy so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_instr[r_wr_ptr] <= mem_data_out;
            r_buf_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    // Decode outputs: head entry, driven to zero whenever the FIFO is empty
    assign instr_valid = (r_occ != '0);
    assign instr       = instr_valid ? r_buf_instr[r_rd_ptr] : 32'h0000_0000;
    assign instr_pc    = instr_valid ? r_buf_pc[r_rd_ptr]    : 32'h0000_0000;

`ifdef FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters: delivered instructions and discarded responses
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'h0000_0000;
            perf_dropped <= 32'h0000_0000;
        end else begin
            if (w_pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect_valid) begin
                // Flushed entries plus a response that arrived in this cycle
                perf_dropped <= perf_dropped + 32'(r_occ) + 32'(w_resp_ok);
            end
        end
    end
`endif

endmodule
